// File: rtl/muldiv_pkg.sv
// muldiv_pkg -- shared constants and types for the sequential multiply/divide unit.
//
// Contents:
//   XLEN, ITER    operand width and iteration count (both 32)
//   CNT_W         width of the iteration counter (must hold the value ITER)
//   OP_*          op encodings: 00 MULTU, 01 DIVU, 10 MULT, 11 DIV
//                 (op[0] selects divide, op[1] selects signed)
//   state_t       FSM state encoding
//
// Configuration macro: MULDIV_SIGNED_EN. The FIX state is only part of the
// enum when this macro is defined.
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = 6;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_DIVU  = 2'b01;
  localparam logic [1:0] OP_MULT  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd3
`ifdef MULDIV_SIGNED_EN
    , FIX = 2'd2
`endif
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step -- combinational single-iteration datapath.
//
// Ports:
//   is_div   1: restoring shift-subtract step, 0: radix-2 shift-add step
//   hi_in    multiply: upper product half / divide: partial remainder
//   lo_in    multiply: lower product half + remaining multiplier bits
//            divide:   remaining dividend bits shifting into quotient bits
//   opd      multiply: multiplicand / divide: divisor
//   hi_out   next upper half / next remainder
//   lo_out   next lower half / next quotient word
//
// Multiply: if the current multiplier LSB is set, add the multiplicand to the
// upper half (33-bit sum keeps the carry), then shift the 65-bit value right
// by one. The carry lands in bit 63, so the 64-bit accumulator never overflows.
// Divide: the 33-bit partial remainder is {rem, next dividend bit}; subtract
// the divisor if it fits and shift a quotient bit in. The stored remainder is
// always below the divisor, so it fits back into 32 bits.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic            is_div,
  input  logic [XLEN-1:0] hi_in,
  input  logic [XLEN-1:0] lo_in,
  input  logic [XLEN-1:0] opd,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic          ge;

  always_comb begin
    sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, opd} : '0);
    shifted = {hi_in, lo_in[XLEN-1]};
    ge      = (shifted >= {1'b0, opd});
    if (is_div) begin
      // When ge holds the true difference is < 2^32, so a 32-bit subtract
      // of the low bits is exact even when shifted[XLEN] is set.
      hi_out = ge ? (shifted[XLEN-1:0] - opd) : shifted[XLEN-1:0];
      lo_out = {lo_in[XLEN-2:0], ge};
    end else begin
      hi_out = sum[XLEN:1];
      lo_out = {sum[0], lo_in[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq -- sequential 32x32 multiply / 32/32 divide unit.
//
// Ports:
//   clk    clock, all state updates on the rising edge
//   rst    synchronous active-high reset (wins over start)
//   start  begin an operation; only sampled in IDLE
//   op     00 MULTU, 01 DIVU, 10 MULT, 11 DIV
//   opa    multiplicand / dividend
//   opb    multiplier / divisor
//   busy   operation in progress (CALC / FIX)
//   done   one-cycle completion pulse (DONE state)
//   hi     product high word / remainder
//   lo     product low word / quotient
//   dz     last completed division had a zero divisor
//
// Configuration macro: MULDIV_SIGNED_EN. When defined, MULT/DIV run on
// operand magnitudes and a one-cycle FIX state restores the signs (latency
// 34). When undefined, op[1] is ignored and every op is unsigned (latency 33).
//
// Timing: start accepted at edge E0; iterations run on edges E0+1..E0+32; at
// E0+33 the FSM leaves CALC (to DONE, or to FIX for signed ops) and outputs are
// loaded on the edge that enters DONE.
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            dz
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             is_div_reg;
  logic [XLEN-1:0]  acc_hi_reg, acc_lo_reg;
  logic [XLEN-1:0]  opd_reg;       // multiplicand or divisor (magnitude)
  logic [XLEN-1:0]  opa_raw_reg;   // original dividend, returned on divide-by-zero
  logic [XLEN-1:0]  hi_reg, lo_reg;
  logic             dz_reg;

  logic [XLEN-1:0]  step_hi, step_lo;
  logic [XLEN-1:0]  a_mag, b_mag;
  logic [XLEN-1:0]  res_hi, res_lo;
  logic             res_dz;
  logic             calc_last;

`ifdef MULDIV_SIGNED_EN
  logic signed_reg;
  logic neg_q_reg;   // product / quotient must be negated
  logic neg_r_reg;   // remainder must be negated (follows dividend sign)

  // Magnitudes of signed operands; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude.
  always_comb begin
    a_mag = (op[1] && opa[XLEN-1]) ? -opa : opa;
    b_mag = (op[1] && opb[XLEN-1]) ? -opb : opb;
  end
`else
  logic op_unused;
  assign op_unused = op[1];
  assign a_mag     = opa;
  assign b_mag     = opb;
`endif

  assign calc_last = (cnt_reg == CNT_W'(ITER));

  muldiv_step u_step (
    .is_div (is_div_reg),
    .hi_in  (acc_hi_reg),
    .lo_in  (acc_lo_reg),
    .opd    (opd_reg),
    .hi_out (step_hi),
    .lo_out (step_lo)
  );

  // Next-state and status outputs.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (calc_last) begin
`ifdef MULDIV_SIGNED_EN
          state_next = signed_reg ? FIX : DONE;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef MULDIV_SIGNED_EN
      FIX: begin
        busy       = 1'b1;
        state_next = DONE;
      end
`endif
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Final result, computed in the cycle that transitions into DONE.
  always_comb begin
    res_hi = acc_hi_reg;
    res_lo = acc_lo_reg;
`ifdef MULDIV_SIGNED_EN
    if (state_reg == FIX) begin
      if (is_div_reg) begin
        if (neg_q_reg) res_lo = -acc_lo_reg;
        if (neg_r_reg) res_hi = -acc_hi_reg;
      end else if (neg_q_reg) begin
        {res_hi, res_lo} = -{acc_hi_reg, acc_lo_reg};
      end
    end
`endif
    // Zero divisor overrides everything, with no sign correction.
    res_dz = is_div_reg && (opd_reg == '0);
    if (res_dz) begin
      res_hi = opa_raw_reg;
      res_lo = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      is_div_reg  <= 1'b0;
      acc_hi_reg  <= '0;
      acc_lo_reg  <= '0;
      opd_reg     <= '0;
      opa_raw_reg <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      dz_reg      <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      signed_reg  <= 1'b0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            cnt_reg     <= '0;
            is_div_reg  <= op[0];
            opa_raw_reg <= opa;
            acc_hi_reg  <= '0;
            // Multiply: multiplier in the low half, multiplicand as operand.
            // Divide: dividend in the low half, divisor as operand.
            acc_lo_reg  <= op[0] ? a_mag : b_mag;
            opd_reg     <= op[0] ? b_mag : a_mag;
`ifdef MULDIV_SIGNED_EN
            signed_reg  <= op[1];
            neg_q_reg   <= op[1] & (opa[XLEN-1] ^ opb[XLEN-1]);
            neg_r_reg   <= op[1] & op[0] & opa[XLEN-1];
`endif
          end
        end
        CALC: begin
          if (!calc_last) begin
            acc_hi_reg <= step_hi;
            acc_lo_reg <= step_lo;
            cnt_reg    <= cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
      if (state_next == DONE) begin
        hi_reg <= res_hi;
        lo_reg <= res_lo;
        dz_reg <= res_dz;
      end
    end
  end

  assign hi = hi_reg;
  assign lo = lo_reg;
  assign dz = dz_reg;

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit: synchronous active-high reset.
REQ-004 Port start, input, 1 bit: request to begin an operation; sampled only in IDLE.
REQ-005 Port op, input, 2 bits: 00 MULTU, 01 DIVU, 10 MULT, 11 DIV.
REQ-006 Port opa, input, 32 bits: multiplicand / dividend.
REQ-007 Port opb, input, 32 bits: multiplier / divisor.
REQ-008 Port busy, output, 1 bit: an operation is in progress.
REQ-009 Port done, output, 1 bit: one-cycle completion pulse.
REQ-010 Port hi, output, 32 bits: product high word / remainder.
REQ-011 Port lo, output, 32 bits: product low word / quotient.
REQ-012 Port dz, output, 1 bit: the last completed division had a divisor of zero.

Function
REQ-013 The FSM SHALL have the states IDLE, CALC, FIX and DONE.
REQ-014 IDLE with start=1 at edge E0 SHALL latch op/opa/opb, clear the iteration counter, enter CALC, and set busy=1.
REQ-015 CALC SHALL perform exactly 32 iterations: radix-2 shift-add for multiply, restoring shift-subtract for divide.
REQ-016 The 64-bit accumulator SHALL carry no overflow beyond 64 bits; the divide partial remainder SHALL be 33 bits.
REQ-017 After the 32nd iteration the FSM SHALL go to FIX for signed ops (macro on) and to DONE otherwise.
REQ-018 FIX SHALL take one cycle and apply sign correction.
REQ-019 FIX sign rules: product sign = sign(opa) XOR sign(opb); quotient sign = sign(opa) XOR sign(opb); remainder sign = sign(opa).
REQ-020 DONE SHALL hold done=1 and busy=0 for exactly one cycle, then return to IDLE.
REQ-021 Unsigned latency: done SHALL be high in the cycle after edge E0+33; signed latency (macro on) SHALL be E0+34.
REQ-022 start SHALL be ignored in CALC, FIX and DONE; a start in DONE SHALL NOT be accepted until IDLE.
REQ-023 hi, lo and dz SHALL update only on entry to DONE and SHALL hold until the next completion.
REQ-024 Divide by zero: the result SHALL be lo=32'hFFFFFFFF, hi=opa (unmodified, no sign fix), dz=1, with normal latency.
REQ-025 dz SHALL be 0 for any multiply and for any division with opb!=0.
REQ-026 MULT/DIV with opa=32'h80000000 SHALL produce the two's-complement truncated result without error (e.g. DIV 80000000/FFFFFFFF -> lo=80000000, hi=0).

Reset
REQ-027 rst=1 at any edge, including mid-operation, SHALL force IDLE, busy=0, done=0, hi=0, lo=0, dz=0 and discard the operation in progress.
REQ-028 When rst and start are both 1 at the same edge, reset SHALL take priority and start SHALL be ignored.

Configuration
REQ-029 Macro MULDIV_SIGNED_EN defined: MULT/DIV SHALL be signed per REQ-019, FIX is used, and signed latency is 34.
REQ-030 Macro MULDIV_SIGNED_EN undefined: op[1] SHALL be ignored, all ops SHALL be unsigned, no FIX state or sign logic SHALL exist, and latency is 33.

Structure
REQ-031 Package muldiv_pkg SHALL hold the XLEN=32 and ITER=32 constants, the op encoding localparams and the FSM state enum.
REQ-032 Sub-module muldiv_step SHALL be the combinational single-iteration datapath: conditional add or trial subtract plus shift, selected by a mul/div bit.

Verification
REQ-033 MULTU FFFFFFFF*FFFFFFFF -> hi=FFFFFFFE, lo=00000001, dz=0; done exactly 33 cycles after start.
REQ-034 DIVU 100/7 -> lo=14, hi=2; DIVU 5/0 -> lo=FFFFFFFF, hi=5, dz=1.
REQ-035 Macro on, MULT -3*5 -> hi=FFFFFFFF, lo=FFFFFFF1 at 34 cycles; macro off, same stimulus -> hi=00000004, lo=FFFFFFF1 at 33 cycles.
REQ-036 Macro on, DIV -7/2 -> lo=FFFFFFFD, hi=FFFFFFFF; DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
REQ-037 start pulsed at cycles 5 and 20 of a running MULTU -> both ignored, exactly one done pulse, busy falls only at DONE.
REQ-038 rst asserted 10 cycles into a DIVU -> next cycle busy=0, hi=lo=0, and no done pulse follows; a new start is then accepted normally.
